// File: rtl/rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_bus_arbiter
//   Shares the RTC chip's multiplexed address/data bus between three requesters
//   (0 = init/config, 1 = user time-set writes, 2 = periodic time readback).
//   A requester is picked round-robin in IDLE. The arbiter then runs one full
//   bus transaction: an address phase and a data phase, each with setup,
//   strobe and hold timing.
//
// Handshake: a requester raises req[i] and holds it, with rnw/addr/wdata
//   stable, until done[i] pulses. The owner's inputs are latched at grant time,
//   so dropping req mid-transaction does not shorten the access.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   req[2:0]        level request per requester
//   rnw[2:0]        per requester: 1 = read, 0 = write
//   addr[23:0]      requester i address  = addr[8i+7:8i]
//   wdata[23:0]     requester i data     = wdata[8i+7:8i]
//   bus_in[7:0]     RTC bus readback
//   grant[2:0]      one-hot owner of the bus
//   done[2:0]       one-hot, 1-cycle pulse at the end of a transaction
//   rdata[7:0]      read data, valid with done, held until the next read
//   busy            high in every state except IDLE
//   cs_n, ad_n      chip select (active low), 0 = address / 1 = data phase
//   wr_n, rd_n      write / read strobes, active low
//   bus_out, bus_oe value driven onto the RTC bus and its output enable
// -----------------------------------------------------------------------------
module rtc_bus_arbiter #(
    parameter int T_SU  = 2,
    parameter int T_STB = 4,
    parameter int T_HD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  rnw,
    input  logic [23:0] addr,
    input  logic [23:0] wdata,
    input  logic [7:0]  bus_in,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        cs_n,
    output logic        ad_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic [7:0]  bus_out,
    output logic        bus_oe
);

    typedef enum logic [2:0] {
        IDLE, A_SU, A_STB, A_HD, D_SU, D_STB, D_HD, DONE
    } state_t;

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [1:0]  ptr, ptr_next;
    logic [1:0]  owner, owner_next;
    logic        lat_rnw, lat_rnw_next;
    logic [7:0]  lat_addr, lat_addr_next;
    logic [7:0]  lat_wdata, lat_wdata_next;

    logic        found;
    logic [1:0]  pick_idx;
    logic [2:0]  scan;
    logic        in_a, in_d;

    logic [2:0]  grant_next, done_next;
    logic [7:0]  rdata_next, bus_out_next;
    logic        busy_next, cs_n_next, ad_n_next, wr_n_next, rd_n_next, bus_oe_next;

    // Dwell length of each timed state, minus one (the counter runs down to 0).
    function automatic logic [7:0] load_val(input state_t s);
        case (s)
            A_SU,  D_SU:  load_val = 8'(T_SU - 1);
            A_STB, D_STB: load_val = 8'(T_STB - 1);
            A_HD,  D_HD:  load_val = 8'(T_HD - 1);
            default:      load_val = 8'd0;
        endcase
    endfunction

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        ptr_next       = ptr;
        owner_next     = owner;
        lat_rnw_next   = lat_rnw;
        lat_addr_next  = lat_addr;
        lat_wdata_next = lat_wdata;
        rdata_next     = rdata;

        // Round-robin scan starting at ptr, wrapping 0->1->2->0.
        found    = 1'b0;
        pick_idx = ptr;
        scan     = 3'd0;
        for (int i = 0; i < 3; i++) begin
            scan = {1'b0, ptr} + 3'(i);
            if (scan >= 3'd3) scan = scan - 3'd3;
            if (!found && req[scan[1:0]]) begin
                found    = 1'b1;
                pick_idx = scan[1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_next     = A_SU;
                    owner_next     = pick_idx;
                    lat_rnw_next   = rnw[pick_idx];
                    lat_addr_next  = addr[{pick_idx, 3'b000} +: 8];
                    lat_wdata_next = wdata[{pick_idx, 3'b000} +: 8];
                end
            end
            DONE: begin
                state_next = IDLE;
                ptr_next   = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
            end
            default: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    case (state)
                        A_SU:    state_next = A_STB;
                        A_STB:   state_next = A_HD;
                        A_HD:    state_next = D_SU;
                        D_SU:    state_next = D_STB;
                        D_STB:   state_next = D_HD;
                        D_HD:    state_next = DONE;
                        default: state_next = IDLE;
                    endcase
                end
                // Sample the bus on the last strobe-low cycle of a read.
                if (state == D_STB && cnt == 8'd0 && lat_rnw) rdata_next = bus_in;
            end
        endcase

        // Shared counter is reloaded on every state entry.
        if (state_next != state) cnt_next = load_val(state_next);

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they belong to.
        in_a = (state_next == A_SU) || (state_next == A_STB) || (state_next == A_HD);
        in_d = (state_next == D_SU) || (state_next == D_STB) || (state_next == D_HD);

        grant_next   = (in_a || in_d) ? (3'b001 << owner_next) : 3'b000;
        done_next    = (state_next == DONE) ? (3'b001 << owner_next) : 3'b000;
        busy_next    = (state_next != IDLE);
        cs_n_next    = !(in_a || in_d);
        ad_n_next    = !in_a;
        wr_n_next    = !((state_next == A_STB) || (state_next == D_STB && !lat_rnw_next));
        rd_n_next    = !(state_next == D_STB && lat_rnw_next);
        bus_oe_next  = in_a || (in_d && !lat_rnw_next);
        bus_out_next = 8'd0;
        if (in_a)                        bus_out_next = lat_addr_next;
        else if (in_d && !lat_rnw_next)  bus_out_next = lat_wdata_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            lat_rnw   <= 1'b0;
            lat_addr  <= 8'd0;
            lat_wdata <= 8'd0;
            grant     <= 3'b000;
            done      <= 3'b000;
            rdata     <= 8'd0;
            busy      <= 1'b0;
            cs_n      <= 1'b1;
            ad_n      <= 1'b1;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            bus_out   <= 8'd0;
            bus_oe    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            lat_rnw   <= lat_rnw_next;
            lat_addr  <= lat_addr_next;
            lat_wdata <= lat_wdata_next;
            grant     <= grant_next;
            done      <= done_next;
            rdata     <= rdata_next;
            busy      <= busy_next;
            cs_n      <= cs_n_next;
            ad_n      <= ad_n_next;
            wr_n      <= wr_n_next;
            rd_n      <= rd_n_next;
            bus_out   <= bus_out_next;
            bus_oe    <= bus_oe_next;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_arbiter
//   Directed bench for rtc_bus_arbiter. Driver tasks push one expected record
//   per transaction; a negedge monitor rebuilds the observed record from the
//   pins and compares it when done pulses. Bus invariants are checked every
//   cycle outside reset.
// -----------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

    localparam int W = 34;
    // Record: [33] d_oe, [32:30] owner, [29] rd, [28:21] aval, [20:13] dval,
    //         [12:9] a strobes, [8:5] d strobes, [4:0] grant-to-done distance
    localparam logic [3:0] EXP_STB = 4'd4;
    // Done rises 16 edges after grant rises: 17 cycles counted inclusively.
    localparam logic [4:0] EXP_LEN = 5'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, rnw;
    logic [23:0] addr, wdata;
    logic [7:0]  bus_in, rd_val;
    logic [2:0]  grant, done;
    logic [7:0]  rdata, bus_out;
    logic        busy, cs_n, ad_n, wr_n, rd_n, bus_oe;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    rtc_bus_arbiter #(.T_SU(2), .T_STB(4), .T_HD(2)) dut (
        .clk(clk), .reset(reset), .req(req), .rnw(rnw), .addr(addr),
        .wdata(wdata), .bus_in(bus_in), .grant(grant), .done(done),
        .rdata(rdata), .busy(busy), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n),
        .rd_n(rd_n), .bus_out(bus_out), .bus_oe(bus_oe)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // RTC model: presents rd_val only while the read strobe is low.
    assign bus_in = rd_n ? 8'hEE : rd_val;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] make_exp(input int idx, input logic rd,
                                              input logic [7:0] aval, input logic [7:0] dval);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        return {!rd, oh, rd, aval, dval, EXP_STB, EXP_STB, EXP_LEN};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_reset_values(input string tag);
        cmp({tag, "_grant"},   grant,   3'b000);
        cmp({tag, "_done"},    done,    3'b000);
        cmp({tag, "_rdata"},   rdata,   8'h00);
        cmp({tag, "_busy"},    busy,    1'b0);
        cmp({tag, "_cs_n"},    cs_n,    1'b1);
        cmp({tag, "_ad_n"},    ad_n,    1'b1);
        cmp({tag, "_wr_n"},    wr_n,    1'b1);
        cmp({tag, "_rd_n"},    rd_n,    1'b1);
        cmp({tag, "_bus_out"}, bus_out, 8'h00);
        cmp({tag, "_bus_oe"},  bus_oe,  1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    task automatic setup_req(input int idx, input logic rd, input logic [7:0] a,
                             input logic [7:0] d);
        rnw[idx]              = rd;
        addr[idx*8 +: 8]      = a;
        wdata[idx*8 +: 8]     = d;
    endtask

    task automatic wait_done(input int idx, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        cmp({name, "_done_timeout"}, 32'(ok), 32'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int         cyc = 0, start_cyc = 0;
    bit         in_txn = 1'b0, rd_seen, d_oe_seen;
    logic [2:0] prev_grant = 3'b000, own;
    logic [3:0] a_cnt, d_cnt;
    logic [7:0] a_val, d_val;
    logic [W-1:0] e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_txn     = 1'b0;
            prev_grant = 3'b000;
        end else begin
            checks++;
            if ((!wr_n && !rd_n) || ((!wr_n || !rd_n) && cs_n) || (bus_oe && !rd_n) ||
                ($countones(grant) > 1) || ($countones(done) > 1)) begin
                errors++;
                $display("FAIL bus_invariant at cycle %0d: cs_n=%b wr_n=%b rd_n=%b bus_oe=%b grant=%b done=%b",
                         cyc, cs_n, wr_n, rd_n, bus_oe, grant, done);
            end
            if (grant != 3'b000 && prev_grant == 3'b000) begin
                in_txn = 1'b1;  start_cyc = cyc;  own = grant;
                a_cnt = 4'd0;   d_cnt = 4'd0;     a_val = 8'd0;  d_val = 8'd0;
                rd_seen = 1'b0; d_oe_seen = 1'b0;
            end
            if (in_txn && !cs_n) begin
                if (!ad_n && !wr_n) begin a_cnt++; a_val = bus_out; end
                if (ad_n && !wr_n)  begin d_cnt++; d_val = bus_out; end
                if (ad_n && !rd_n)  begin d_cnt++; rd_seen = 1'b1; end
                if (ad_n && bus_oe) d_oe_seen = 1'b1;
            end
            if (done != 3'b000) begin
                if (!in_txn || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=%b with nothing expected", done);
                end else begin
                    e = exp_q.pop_front();
                    cmp("txn_done_owner",  done,                     e[32:30]);
                    cmp("txn_grant_owner", own,                      e[32:30]);
                    cmp("txn_is_read",     rd_seen,                  e[29]);
                    cmp("txn_addr_value",  a_val,                    e[28:21]);
                    cmp("txn_data_value",  rd_seen ? rdata : d_val,  e[20:13]);
                    cmp("txn_addr_strobe", a_cnt,                    e[12:9]);
                    cmp("txn_data_strobe", d_cnt,                    e[8:5]);
                    cmp("txn_length",      cyc - start_cyc,          e[4:0]);
                    cmp("txn_data_oe",     d_oe_seen,                e[33]);
                end
                in_txn = 1'b0;
            end
            prev_grant = grant;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_done;
        reset = 1'b1; req = 3'b000; rnw = 3'b000;
        addr = 24'd0; wdata = 24'd0; rd_val = 8'h00;
        do_reset();

        // 1) write by requester 1; grant must appear one cycle later
        setup_req(1, 1'b0, 8'h21, 8'h45);
        exp_q.push_back(make_exp(1, 1'b0, 8'h21, 8'h45));
        req = 3'b010;
        @(negedge clk);
        cmp("grant_latency", grant, 3'b010);
        wait_done(1, "t1");
        req = 3'b000;

        // 2) read by requester 2, RTC returns 59
        repeat (2) @(negedge clk);
        setup_req(2, 1'b1, 8'h22, 8'h00);
        rd_val = 8'h59;
        exp_q.push_back(make_exp(2, 1'b1, 8'h22, 8'h59));
        req = 3'b100;
        wait_done(2, "t2");
        req = 3'b000;
        repeat (2) @(negedge clk);
        cmp("rdata_held", rdata, 8'h59);

        // 3) all three held after reset: order 0,1,2,0
        do_reset();
        setup_req(0, 1'b0, 8'h31, 8'h41);
        setup_req(1, 1'b1, 8'h32, 8'h00);
        setup_req(2, 1'b0, 8'h33, 8'h43);
        rd_val = 8'hA7;
        exp_q.push_back(make_exp(0, 1'b0, 8'h31, 8'h41));
        exp_q.push_back(make_exp(1, 1'b1, 8'h32, 8'hA7));
        exp_q.push_back(make_exp(2, 1'b0, 8'h33, 8'h43));
        exp_q.push_back(make_exp(0, 1'b0, 8'h31, 8'h41));
        req = 3'b111;
        n_done = 0;
        for (int k = 0; k < 200 && n_done < 4; k++) begin
            @(negedge clk);
            if (done != 3'b000) begin
                n_done++;
                if (n_done == 4) req = 3'b000;
            end
        end
        cmp("rr_done_count", n_done, 4);

        // 4) reset during the data strobe of a write aborts with no done
        repeat (2) @(negedge clk);
        setup_req(0, 1'b0, 8'h61, 8'h62);
        req = 3'b001;
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!cs_n && ad_n && !wr_n) begin hit = 1'b1; break; end
            end
            cmp("abort_reach_dstb", 32'(hit), 32'd1);
        end
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        check_reset_values("abort");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        setup_req(0, 1'b0, 8'h63, 8'h64);
        exp_q.push_back(make_exp(0, 1'b0, 8'h63, 8'h64));
        req = 3'b001;
        wait_done(0, "t4");
        req = 3'b000;

        // 5) requester 0 drops req during the address hold; access completes
        repeat (2) @(negedge clk);
        setup_req(0, 1'b1, 8'h71, 8'h00);
        rd_val = 8'h72;
        exp_q.push_back(make_exp(0, 1'b1, 8'h71, 8'h72));
        req = 3'b001;
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (grant[0]) begin hit = 1'b1; break; end
            end
            cmp("drop_grant_seen", 32'(hit), 32'd1);
        end
        repeat (6) @(posedge clk);
        #1 req = 3'b000;
        wait_done(0, "t5");

        repeat (10) @(negedge clk);
        cmp("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
